// File: rtl/mips_pkg.sv
// Shared constants, encodings and types for the multicycle MIPS control unit.
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned SRC_B_W  = 2;
  localparam int unsigned PC_SRC_W = 2;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_SRA = 6'b000011;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'b100110;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SRA = 3'b100;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b110;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b111;

  // Datapath select encodings
  localparam logic SRC_A_PC  = 1'b0;
  localparam logic SRC_A_REG = 1'b1;

  localparam logic [SRC_B_W-1:0] SRC_B_REG    = 2'b00;
  localparam logic [SRC_B_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SRC_B_W-1:0] SRC_B_IMM    = 2'b10;
  localparam logic [SRC_B_W-1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [PC_SRC_W-1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_SRC_TGT  = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_BNE  = 3'd5,
    CLS_J    = 3'd6
  } cls_t;

  // Full control word driven to the datapath each cycle
  typedef struct packed {
    logic                mem_req;
    logic                mem_we;
    logic                ir_we;
    logic                pc_we;
    logic                tgt_we;
    logic                reg_we;
    logic                alu_src_a;
    logic [SRC_B_W-1:0]  alu_src_b;
    logic [ALU_W-1:0]    alu_func;
    logic [PC_SRC_W-1:0] pc_src;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_control_alu_decoder.sv
// R-type funct field to ALU operation decoder, flags unknown functs.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   func_c,
  output logic               bad_funct_c
);

  // Map funct to ALU op; anything outside the supported set is flagged
  always_comb begin
    func_c      = ALU_ADD;
    bad_funct_c = 1'b0;
    case (funct)
      FN_ADD:  func_c = ALU_ADD;
      FN_SUB:  func_c = ALU_SUB;
      FN_SLL:  func_c = ALU_SLL;
      FN_SRL:  func_c = ALU_SRL;
      FN_SRA:  func_c = ALU_SRA;
      FN_OR:   func_c = ALU_OR;
      FN_AND:  func_c = ALU_AND;
      FN_XOR:  func_c = ALU_XOR;
      default: bad_funct_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature: define MIPS_CTRL_BNE_EN to decode BNE as an inverted BEQ.
// Outputs are decoded from registered state; started_q keeps them at zero
// from reset assertion until the first clock edge after release.
module mips_control
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                z_flag,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic                tgt_we,
  output logic                reg_we,
  output logic                alu_src_a,
  output logic [SRC_B_W-1:0]  alu_src_b,
  output logic [ALU_W-1:0]    alu_func,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal
);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [ALU_W-1:0] rfunc_q, rfunc_d;
  logic             started_q;
  cls_t             op_cls;
  logic             op_legal;
  logic [ALU_W-1:0] dec_func;
  logic             dec_bad;
  ctrl_t            ctrl;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .func_c      (dec_func),
    .bad_funct_c (dec_bad)
  );

  // Classify the live opcode; only consumed in DECODE
  always_comb begin
    op_cls   = CLS_R;
    op_legal = 1'b1;
    case (op)
      OP_RTYPE: op_legal = !dec_bad;
      OP_ADDI:  op_cls   = CLS_ADDI;
      OP_LW:    op_cls   = CLS_LW;
      OP_SW:    op_cls   = CLS_SW;
      OP_BEQ:   op_cls   = CLS_BEQ;
      OP_J:     op_cls   = CLS_J;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:   op_cls   = CLS_BNE;
`endif
      default:  op_legal = 1'b0;
    endcase
  end

  // State, latched instruction class and R-type ALU op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_R;
      rfunc_q   <= ALU_ADD;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rfunc_q   <= rfunc_d;
      started_q <= 1'b1;
    end
  end

  // Next-state and control word decode
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    rfunc_d = rfunc_q;
    ctrl    = '0;
    if (!started_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_req   = 1'b1;
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_FOUR;
          ctrl.alu_func  = ALU_ADD;
          if (mem_ready) begin
            ctrl.ir_we  = 1'b1;
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_ALU;
            state_d     = S_DECODE;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_a = SRC_A_PC;
          ctrl.alu_src_b = SRC_B_IMM_SH;
          ctrl.alu_func  = ALU_ADD;
          ctrl.tgt_we    = 1'b1;
          if (op_legal) begin
            cls_d   = op_cls;
            rfunc_d = dec_func;
            state_d = S_EXEC;
          end else begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        end
        S_EXEC: begin
          case (cls_q)
            CLS_R: begin
              ctrl.alu_src_a = SRC_A_REG;
              ctrl.alu_src_b = SRC_B_REG;
              ctrl.alu_func  = rfunc_q;
              state_d        = S_WB;
            end
            CLS_ADDI, CLS_LW, CLS_SW: begin
              ctrl.alu_src_a = SRC_A_REG;
              ctrl.alu_src_b = SRC_B_IMM;
              ctrl.alu_func  = ALU_ADD;
              state_d        = (cls_q == CLS_ADDI) ? S_WB : S_MEM;
            end
            CLS_BEQ, CLS_BNE: begin
              ctrl.alu_src_a = SRC_A_REG;
              ctrl.alu_src_b = SRC_B_REG;
              ctrl.alu_func  = ALU_SUB;
              ctrl.pc_we     = (cls_q == CLS_BEQ) ? z_flag : !z_flag;
              ctrl.pc_src    = PC_SRC_TGT;
              state_d        = S_FETCH;
            end
            CLS_J: begin
              ctrl.pc_we  = 1'b1;
              ctrl.pc_src = PC_SRC_JUMP;
              state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          ctrl.mem_req = 1'b1;
          ctrl.mem_we  = (cls_q == CLS_SW);
          if (mem_ready) begin
            state_d = (cls_q == CLS_SW) ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          ctrl.reg_we     = 1'b1;
          ctrl.reg_dst    = (cls_q == CLS_R);
          ctrl.mem_to_reg = (cls_q == CLS_LW);
          state_d         = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Drive the datapath control pins from the control word
  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign tgt_we     = ctrl.tgt_we;
  assign reg_we     = ctrl.reg_we;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_func   = ctrl.alu_func;
  assign pc_src     = ctrl.pc_src;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mips_control.sv
// Table-driven bench for mips_control: one record per clock cycle, plus
// hand sequences for reset release and asynchronous abort during MEM.
// Honours MIPS_CTRL_BNE_EN the same way the design does.
module tb_mips_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       z_flag, mem_ready;
  logic       mem_req, mem_we, ir_we, pc_we, tgt_we, reg_we, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_func;
  logic       reg_dst, mem_to_reg, illegal;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] OPR = 6'b000000, OPADDI = 6'b001000, OPLW = 6'b100011,
                         OPSW = 6'b101011, OPBEQ = 6'b000100, OPBNE = 6'b000101,
                         OPJ = 6'b000010, OPBAD = 6'b111111;

  always #5 clk = ~clk;

  mips_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .z_flag(z_flag),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .tgt_we(tgt_we), .reg_we(reg_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_func(alu_func), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal)
  );

  // Observed control word, fields in the order of function c() below
  logic [16:0] act;
  assign act = {mem_req, mem_we, ir_we, pc_we, tgt_we, reg_we, alu_src_a,
                alu_src_b, alu_func, pc_src, reg_dst, mem_to_reg, illegal};

  function automatic logic [16:0] c(input logic req, we, ir, pcw, tgt, rw, sa,
                                    input logic [1:0] sb, input logic [2:0] af,
                                    input logic [1:0] ps, input logic rd, m2r, ill);
    return {req, we, ir, pcw, tgt, rw, sa, sb, af, ps, rd, m2r, ill};
  endfunction

  function automatic logic [16:0] f_wait();  return c(1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] f_done();  return c(1,0,1,1,0,0,0,2'b01,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] dec();     return c(0,0,0,0,1,0,0,2'b11,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] dec_ill(); return c(0,0,0,0,1,0,0,2'b11,3'b000,2'b00,0,0,1); endfunction
  function automatic logic [16:0] e_r(input logic [2:0] af); return c(0,0,0,0,0,0,1,2'b00,af,2'b00,0,0,0); endfunction
  function automatic logic [16:0] e_i();     return c(0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] e_br(input logic pcw); return c(0,0,0,pcw,0,0,1,2'b00,3'b001,2'b01,0,0,0); endfunction
  function automatic logic [16:0] e_j();     return c(0,0,0,1,0,0,0,2'b00,3'b000,2'b10,0,0,0); endfunction
  function automatic logic [16:0] mem(input logic we); return c(1,we,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] wb_r();    return c(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,0,0); endfunction
  function automatic logic [16:0] wb_i();    return c(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,0); endfunction
  function automatic logic [16:0] wb_l();    return c(0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0); endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [5:0] o, f, input logic z, r, input logic [16:0] e);
    vec_t v;
    v.op = o; v.funct = f; v.z = z; v.rdy = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%05h want=%05h", name, act, exp);
    end
  endtask

  logic [5:0] rf[8];
  logic [2:0] ra[8];

  initial begin
    rf = '{6'b100000, 6'b100010, 6'b000000, 6'b000010, 6'b000011, 6'b100101, 6'b100100, 6'b100110};
    ra = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

    // ADD; mem_ready high in DECODE/EXEC/WB is ignored; op/funct change in EXEC ignored
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPR, 6'b100000, 0, 1, dec());
    row(OPBAD, 6'b101010, 0, 1, e_r(3'b000));
    row(OPR, 6'b000000, 0, 1, wb_r());
    // Every R-type funct
    for (int i = 0; i < 8; i++) begin
      row(OPR, 6'b000000, 0, 1, f_done());
      row(OPR, rf[i], 0, 0, dec());
      row(OPR, rf[i], 0, 0, e_r(ra[i]));
      row(OPR, rf[i], 0, 0, wb_r());
    end
    // ADDI with one FETCH wait cycle
    row(OPR, 6'b000000, 0, 0, f_wait());
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPADDI, 6'b000000, 0, 0, dec());
    row(OPADDI, 6'b000000, 0, 0, e_i());
    row(OPADDI, 6'b000000, 0, 0, wb_i());
    // SW with zero-wait MEM
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPSW, 6'b000000, 0, 0, dec());
    row(OPSW, 6'b000000, 0, 0, e_i());
    row(OPSW, 6'b000000, 0, 1, mem(1));
    // LW with 3 wait cycles in MEM
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPLW, 6'b000000, 0, 0, dec());
    row(OPLW, 6'b000000, 0, 1, e_i());
    row(OPLW, 6'b000000, 0, 0, mem(0));
    row(OPLW, 6'b000000, 0, 0, mem(0));
    row(OPLW, 6'b000000, 0, 0, mem(0));
    row(OPLW, 6'b000000, 0, 1, mem(0));
    row(OPLW, 6'b000000, 0, 0, wb_l());
    // BEQ taken then not taken
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPBEQ, 6'b000000, 0, 0, dec());
    row(OPBEQ, 6'b000000, 1, 0, e_br(1));
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPBEQ, 6'b000000, 1, 0, dec());
    row(OPBEQ, 6'b000000, 0, 0, e_br(0));
    // J
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPJ, 6'b000000, 1, 0, dec());
    row(OPJ, 6'b000000, 1, 0, e_j());
    // Illegal opcode, then illegal funct; both return to FETCH
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPBAD, 6'b000000, 0, 0, dec_ill());
    row(OPR, 6'b000000, 0, 0, f_wait());
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPR, 6'b101010, 0, 0, dec_ill());
    // BNE
    row(OPR, 6'b000000, 0, 1, f_done());
`ifdef MIPS_CTRL_BNE_EN
    row(OPBNE, 6'b000000, 0, 0, dec());
    row(OPBNE, 6'b000000, 0, 0, e_br(1));
    row(OPR, 6'b000000, 0, 1, f_done());
    row(OPBNE, 6'b000000, 0, 0, dec());
    row(OPBNE, 6'b000000, 1, 0, e_br(0));
`else
    row(OPBNE, 6'b000000, 0, 0, dec_ill());
`endif

    // Reset held: all outputs low
    rst_n = 1'b0; op = '0; funct = '0; z_flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_hold", 17'h0);
    rst_n = 1'b1; #1;
    check("pre_first_edge", 17'h0);

    // Table: drive on the falling edge, compare 1 time unit later
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      op = tbl[i].op; funct = tbl[i].funct; z_flag = tbl[i].z; mem_ready = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Asynchronous reset during an outstanding LW memory request
    @(negedge clk); op = OPR; funct = '0; z_flag = 1'b0; mem_ready = 1'b1; #1;
    check("abort_fetch", f_done());
    @(negedge clk); op = OPLW; mem_ready = 1'b0; #1;
    check("abort_decode", dec());
    @(negedge clk); #1;
    check("abort_exec", e_i());
    @(negedge clk); #1;
    check("abort_mem_req", mem(0));
    #2 rst_n = 1'b0; #1;
    check("abort_async_drop", 17'h0);
    @(negedge clk); #1;
    rst_n = 1'b1; #1;
    check("abort_post_release", 17'h0);
    @(negedge clk); op = OPR; funct = 6'b100000; #1;
    check("restart_fetch", f_wait());
    mem_ready = 1'b1; #1;
    check("restart_fetch_done", f_done());
    @(negedge clk); mem_ready = 1'b0; #1;
    check("restart_decode", dec());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
